// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : EX-stage execution unit. Logic ops, ADD/SUB and SLT finish
//               in one cycle. SLL/SRL run on an iterative shifter and stall
//               the pipeline through the valid/ready handshake and busy_o.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SLL  = 4'b1000;
    localparam logic [3:0] c_OP_SRL  = 4'b1001;
    localparam logic [3:0] c_OP_NOR  = 4'b1100;
    localparam logic [3:0] c_OP_NAND = 4'b1101;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [4:0] c_STEP = 5'(SHIFT_STEP);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_acc;
    logic [4:0]        r_cnt;
    logic              r_shift_left;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_overflow;
    logic              r_valid;

    logic              w_accept;
    logic              w_is_shift;
    logic [4:0]        w_step;
    logic [4:0]        w_cnt_next;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_overflow;

    assign w_accept   = valid_i & ready_o & ~flush_i;
    assign w_is_shift = (ctrl_i == c_OP_SLL) || (ctrl_i == c_OP_SRL);

    // Last shift step may be shorter than SHIFT_STEP so the count lands exactly on 0
    assign w_step     = (r_cnt < c_STEP) ? r_cnt : c_STEP;
    assign w_cnt_next = r_cnt - w_step;
    assign w_shifted  = r_shift_left ? (r_acc << w_step) : (r_acc >> w_step);

    assign w_sum  = src1_i + src2_i;
    assign w_diff = src1_i - src2_i;

    // Single-cycle ALU; overflow only when operand signs make it possible
    always_comb begin
        w_alu_result   = '0;
        w_alu_overflow = 1'b0;
        case (ctrl_i)
            c_OP_AND:  w_alu_result = src1_i & src2_i;
            c_OP_OR:   w_alu_result = src1_i | src2_i;
            c_OP_ADD: begin
                w_alu_result   = w_sum;
                w_alu_overflow = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                                 (w_sum[DATA_W-1] != src1_i[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_alu_result   = w_diff;
                w_alu_overflow = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                                 (w_diff[DATA_W-1] != src1_i[DATA_W-1]);
            end
            c_OP_SLT:  w_alu_result[0] = ($signed(src1_i) < $signed(src2_i));
            c_OP_NOR:  w_alu_result = ~(src1_i | src2_i);
            c_OP_NAND: w_alu_result = ~(src1_i & src2_i);
            default:   w_alu_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush aborts from any state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_is_shift && (shamt_i != 5'd0)) ? c_ST_SHIFT : c_ST_DONE;
                end
            end
            c_ST_SHIFT: begin
                if (w_cnt_next == 5'd0) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (ready_i) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
        if (flush_i) begin
            w_next_state = c_ST_IDLE;
        end
    end

    // Handshake outputs; ready is masked while reset is asserted
    always_comb begin
        ready_o = (r_state == c_ST_IDLE) && !rst_i;
        busy_o  = (r_state != c_ST_IDLE);
    end

    // Datapath: shifter accumulator and registered result; flush keeps result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_shift_left <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
            r_valid      <= 1'b0;
        end else if (flush_i) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift) begin
                            r_acc        <= src2_i;
                            r_cnt        <= shamt_i;
                            r_shift_left <= (ctrl_i == c_OP_SLL);
                            if (shamt_i == 5'd0) begin
                                r_result   <= src2_i;
                                r_zero     <= (src2_i == '0);
                                r_overflow <= 1'b0;
                                r_valid    <= 1'b1;
                            end
                        end else begin
                            r_result   <= w_alu_result;
                            r_zero     <= (w_alu_result == '0);
                            r_overflow <= w_alu_overflow;
                            r_valid    <= 1'b1;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == 5'd0) begin
                        r_result   <= w_shifted;
                        r_zero     <= (w_shifted == '0);
                        r_overflow <= 1'b0;
                        r_valid    <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign result_o   = r_result;
    assign zero_o     = r_zero;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. Two instances
//               (SHIFT_STEP=1 and SHIFT_STEP=4); expected results are queued
//               at issue time and compared when valid_o rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic [6:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, valid_drv, sel4, ready_in;
    logic [3:0]  ctrl;
    logic [31:0] src1, src2;
    logic [4:0]  shamt;
    logic        valid1, valid4;

    logic        ready1, vout1, zero1, ovf1, busy1;
    logic [31:0] result1;
    logic        ready4, vout4, zero4, ovf4, busy4;
    logic [31:0] result4;

    logic        m_ready, m_valid, m_zero, m_ovf, m_busy;
    logic [31:0] m_result;

    exp_t        q[$];
    logic [31:0] last_res;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    assign valid1   = valid_drv & ~sel4;
    assign valid4   = valid_drv & sel4;
    assign m_ready  = sel4 ? ready4  : ready1;
    assign m_valid  = sel4 ? vout4   : vout1;
    assign m_zero   = sel4 ? zero4   : zero1;
    assign m_ovf    = sel4 ? ovf4    : ovf1;
    assign m_busy   = sel4 ? busy4   : busy1;
    assign m_result = sel4 ? result4 : result1;

    alu_exec_unit #(.DATA_W(32), .SHIFT_STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid1), .ready_o(ready1),
        .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
        .valid_o(vout1), .ready_i(ready_in), .result_o(result1), .zero_o(zero1),
        .overflow_o(ovf1), .busy_o(busy1)
    );

    alu_exec_unit #(.DATA_W(32), .SHIFT_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid4), .ready_o(ready4),
        .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
        .valid_o(vout4), .ready_i(ready_in), .result_o(result4), .zero_o(zero4),
        .overflow_o(ovf4), .busy_o(busy4)
    );

    // Reference model of one operation, including its expected latency
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh, input int step);
        exp_t   e;
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        e.res = '0;
        e.ov  = 1'b0;
        e.lat = 7'd1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                e.res = a + b;
                s = sa + sb;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                e.res = a - b;
                s = sa - sb;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin
                e.res = b << sh;
                e.lat = 7'(1 + (int'(sh) + step - 1) / step);
            end
            4'b1001: begin
                e.res = b >> sh;
                e.lat = 7'(1 + (int'(sh) + step - 1) / step);
            end
            4'b1100: e.res = ~(a | b);
            4'b1101: e.res = ~(a & b);
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Wait for ready, present one op for one cycle, optionally queue its expectation
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push);
        int w = 0;
        while (!m_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!m_ready) begin
            total++;
            $display("FAIL issue_timeout: ready_o got %b required 1", m_ready);
        end
        ctrl = op; src1 = a; src2 = b; shamt = sh;
        valid_drv = 1'b1;
        if (push) q.push_back(model(op, a, b, sh, sel4 ? 4 : 1));
        @(negedge clk);
        valid_drv = 1'b0;
    endtask

    // Wait for valid_o, pop the scoreboard and compare latency/result/flags/busy
    task automatic collect(input string name);
        int   lat = 1;
        logic busy_all = 1'b1;
        exp_t e;
        while (1) begin
            busy_all &= m_busy;
            if (m_valid || lat >= 100) break;
            @(negedge clk);
            lat++;
        end
        total++;
        if (!m_valid) begin
            $display("FAIL %s_timeout: valid_o got %b required 1", name, m_valid);
            if (q.size() != 0) void'(q.pop_front());
            return;
        end
        passed++;
        total++;
        if (q.size() == 0) begin
            $display("FAIL %s_queue: scoreboard empty got 0 entries required 1", name);
            return;
        end
        passed++;
        e = q.pop_front();
        last_res = e.res;
        total++;
        if (lat !== int'(e.lat)) $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
        else passed++;
        total++;
        if (m_result !== e.res) $display("FAIL %s_result: got %h required %h", name, m_result, e.res);
        else passed++;
        total++;
        if (m_zero !== e.z) $display("FAIL %s_zero: got %b required %b", name, m_zero, e.z);
        else passed++;
        total++;
        if (m_ovf !== e.ov) $display("FAIL %s_overflow: got %b required %b", name, m_ovf, e.ov);
        else passed++;
        total++;
        if (busy_all !== 1'b1) $display("FAIL %s_busy: got %b required 1", name, busy_all);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ready1 !== 1'b0) $display("FAIL reset_ready: got %b required 0", ready1); else passed++;
        total++;
        if ({vout1, zero1, ovf1, busy1} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {vout1, zero1, ovf1, busy1}); else passed++;
        total++;
        if (result1 !== 32'd0) $display("FAIL reset_result: got %h required 00000000", result1); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready1 !== 1'b1 || ready4 !== 1'b1) $display("FAIL reset_release_ready: got %b%b required 11", ready1, ready4); else passed++;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops [10] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001,
                                  4'b1100, 4'b1101, 4'b0011, 4'b0110, 4'b0111};
        logic [31:0] as  [10] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h0F00_0001,
                                  32'h0000_00FF, 32'hFFFF_0000, 32'h1234_5678, 32'h8000_0000, 32'h1};
        logic [31:0] bs  [10] = '{32'h1, 32'd5, 32'h1, 32'h0FF0_FFFF, 32'h0000_1000,
                                  32'hFF00_0000, 32'hFF00_FFFF, 32'h9ABC_DEF0, 32'h1, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], as[i], bs[i], 5'd0, 1'b1);
            collect($sformatf("alu%0d", i));
        end
    endtask

    task automatic test_shift_step1();
        issue(4'b1000, 32'h0, 32'h1, 5'd31, 1'b1);
        collect("sll31_s1");
        issue(4'b1000, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1);
        collect("sll0_s1");
        issue(4'b1001, 32'h0, 32'hF000_0000, 5'd5, 1'b1);
        collect("srl5_s1");
    endtask

    task automatic test_shift_step4();
        sel4 = 1'b1;
        issue(4'b1001, 32'h0, 32'hF000_0000, 5'd5, 1'b1);
        collect("srl5_s4");
        issue(4'b1000, 32'h0, 32'h0000_00A5, 5'd8, 1'b1);
        collect("sll8_s4");
        issue(4'b1000, 32'h0, 32'h8000_0000, 5'd31, 1'b1);
        collect("sll31_s4");
        sel4 = 1'b0;
    endtask

    task automatic test_backpressure();
        int w = 0;
        exp_t e;
        ready_in = 1'b0;
        issue(4'b0010, 32'd3, 32'd4, 5'd0, 1'b1);
        while (!m_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        e = q[0];
        ctrl = 4'b0001; src1 = 32'hFFFF_FFFF; src2 = 32'h1; valid_drv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (m_valid !== 1'b1 || m_result !== e.res)
                $display("FAIL hold_%0d: valid/result got %b/%h required 1/%h", k, m_valid, m_result, e.res);
            else passed++;
            total++;
            if (m_ready !== 1'b0) $display("FAIL hold_ready_%0d: got %b required 0", k, m_ready); else passed++;
            @(negedge clk);
        end
        valid_drv = 1'b0;
        ready_in  = 1'b1;
        collect("bp_release");
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || m_busy !== 1'b0 || q.size() != 0)
            $display("FAIL bp_ignored_input: valid/busy got %b/%b required 0/0", m_valid, m_busy);
        else passed++;
    endtask

    task automatic test_flush();
        logic stay_low = 1'b1;
        issue(4'b0010, 32'h10, 32'h20, 5'd0, 1'b1);
        collect("pre_flush");
        issue(4'b1000, 32'h0, 32'h1, 5'd31, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_ready !== 1'b1)
            $display("FAIL flush_state: busy/valid/ready got %b/%b/%b required 0/0/1", m_busy, m_valid, m_ready);
        else passed++;
        total++;
        if (m_result !== last_res) $display("FAIL flush_result_hold: got %h required %h", m_result, last_res); else passed++;
        for (int k = 0; k < 40; k++) begin
            stay_low &= ~m_valid;
            @(negedge clk);
        end
        total++;
        if (stay_low !== 1'b1) $display("FAIL flush_valid_low: got %b required 1", stay_low); else passed++;
        ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1; valid_drv = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid_drv = 1'b0; flush = 1'b0;
        total++;
        if (m_busy !== 1'b0) $display("FAIL flush_blocks_accept: busy got %b required 0", m_busy); else passed++;
        issue(4'b0010, 32'h0000_0100, 32'hFFFF_FFFF, 5'd0, 1'b1);
        collect("post_flush_add");
    endtask

    task automatic test_reset_mid_shift();
        issue(4'b1001, 32'h0, 32'hFFFF_FFFF, 5'd20, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({vout1, zero1, ovf1, busy1, ready1} !== 5'b0)
            $display("FAIL midshift_reset_flags: got %b required 00000", {vout1, zero1, ovf1, busy1, ready1});
        else passed++;
        total++;
        if (result1 !== 32'd0) $display("FAIL midshift_reset_result: got %h required 00000000", result1); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1100, 4'b1101};
        for (int i = 0; i < 8; i++) begin
            issue(ops[$urandom_range(0, 8)], $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
            collect($sformatf("b2b%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_drv = 1'b0; sel4 = 1'b0; ready_in = 1'b1;
        ctrl = '0; src1 = '0; src2 = '0; shamt = '0; last_res = '0;
        @(negedge clk);
        test_reset();
        test_single_cycle();
        test_shift_step1();
        test_shift_step4();
        test_backpressure();
        test_flush();
        test_reset_mid_shift();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
